// File: rtl/payoff_pkg.sv
// Shared option-type encoding and default datapath width for the payoff stage.
// No logic; constants only. No backpressure.
package payoff_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OPT_CALL     = 2'b00;
    localparam logic [1:0] OPT_PUT      = 2'b01;
    localparam logic [1:0] OPT_DIG_CALL = 2'b10;
    localparam logic [1:0] OPT_DIG_PUT  = 2'b11;

endpackage

// File: rtl/payoff_intrinsic.sv
// Intrinsic payoff for vanilla/digital calls and puts from S_T and K.
// Latency 0 (purely combinational). No backpressure.
module payoff_intrinsic
    import payoff_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CASH_AMOUNT = WIDTH'(1)
) (
    input  logic [WIDTH-1:0] S_T,
    input  logic [WIDTH-1:0] K,
    input  logic [1:0]       option_type,
    output logic [WIDTH-1:0] next_payoff,
    output logic             next_itm
);

    logic st_gt_k;
    logic k_gt_st;

    assign st_gt_k = S_T > K;
    assign k_gt_st = K > S_T;

    // Subtract only on the winning side so the difference can never wrap.
    always_comb begin
        next_payoff = '0;
        next_itm    = 1'b0;
        case (option_type)
            OPT_CALL: begin
                next_itm = st_gt_k;
                if (st_gt_k) next_payoff = S_T - K;
            end
            OPT_PUT: begin
                next_itm = k_gt_st;
                if (k_gt_st) next_payoff = K - S_T;
            end
            OPT_DIG_CALL: begin
                next_itm = st_gt_k;
                if (st_gt_k) next_payoff = CASH_AMOUNT;
            end
            default: begin
                next_itm = k_gt_st;
                if (k_gt_st) next_payoff = CASH_AMOUNT;
            end
        endcase
    end

endmodule

// File: rtl/payoff_calculator.sv
// Registered European option payoff stage at the end of the path pipeline.
// Latency 1 cycle; outputs hold while en is low. No backpressure (en gates loading only).
module payoff_calculator
    import payoff_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CASH_AMOUNT = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] S_T,
    input  logic [WIDTH-1:0] K,
    input  logic [1:0]       option_type,
    output logic [WIDTH-1:0] payoff,
    output logic             payoff_valid,
    output logic             in_the_money
);

    logic [WIDTH-1:0] next_payoff;
    logic             next_itm;

    payoff_intrinsic #(
        .WIDTH       (WIDTH),
        .CASH_AMOUNT (CASH_AMOUNT)
    ) u_intrinsic (
        .S_T         (S_T),
        .K           (K),
        .option_type (option_type),
        .next_payoff (next_payoff),
        .next_itm    (next_itm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            payoff       <= '0;
            payoff_valid <= 1'b0;
            in_the_money <= 1'b0;
        end else begin
            payoff_valid <= en;
            if (en) begin
                payoff       <= next_payoff;
                in_the_money <= next_itm;
            end
        end
    end

endmodule

// File: tb/tb_payoff_calculator.sv
// Directed bench for payoff_calculator with a behavioural reference model
// and hand-computed literal expectations.
module tb_payoff_calculator;

    localparam int          W    = 32;
    localparam logic [31:0] CASH = 32'd1000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] S_T;
    logic [31:0] K;
    logic [1:0]  option_type;
    logic [31:0] payoff;
    logic        payoff_valid;
    logic        in_the_money;

    payoff_calculator #(
        .WIDTH       (W),
        .CASH_AMOUNT (CASH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .S_T          (S_T),
        .K            (K),
        .option_type  (option_type),
        .payoff       (payoff),
        .payoff_valid (payoff_valid),
        .in_the_money (in_the_money)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state, known only after the first reset edge.
    bit          model_ok = 1'b0;
    logic [31:0] m_payoff;
    logic        m_valid;
    logic        m_itm;

    // Payoff from the option definitions using wide signed arithmetic.
    function automatic void ref_payoff(input logic [31:0] s, input logic [31:0] k,
                                       input logic [1:0] t,
                                       output logic [31:0] p, output logic itm);
        longint sv = longint'(s);
        longint kv = longint'(k);
        longint gain;
        gain = t[0] ? (kv - sv) : (sv - kv);
        itm  = gain > 0;
        if (!itm)     p = 32'd0;
        else if (t[1]) p = CASH;
        else           p = gain[31:0];
    endfunction

    task automatic step(input logic r, input logic e, input logic [31:0] s,
                        input logic [31:0] k, input logic [1:0] t);
        logic [31:0] p;
        logic        i;
        @(negedge clk);
        rst = r; en = e; S_T = s; K = k; option_type = t;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_payoff = 32'd0; m_valid = 1'b0; m_itm = 1'b0;
        end else begin
            m_valid = e;
            if (e) begin
                ref_payoff(s, k, t, p, i);
                m_payoff = p;
                m_itm    = i;
            end
        end
        model_ok = 1'b1;
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] p,
                       input logic v, input logic i);
        checks++;
        if (payoff !== p || payoff_valid !== v || in_the_money !== i) begin
            errors++;
            $display("FAIL %s: got payoff=%h valid=%b itm=%b, need payoff=%h valid=%b itm=%b",
                     name, payoff, payoff_valid, in_the_money, p, v, i);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (payoff !== m_payoff || payoff_valid !== m_valid || in_the_money !== m_itm) begin
                errors++;
                $display("FAIL model cycle %0d: got payoff=%h valid=%b itm=%b, need payoff=%h valid=%b itm=%b",
                         cyc, payoff, payoff_valid, in_the_money, m_payoff, m_valid, m_itm);
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; S_T = '0; K = '0; option_type = 2'b00;

        step(1'b1, 1'b0, 32'd123, 32'd45, 2'b00);
        lit("reset", 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd123, 32'd45, 2'b00);
        lit("after_reset", 32'd0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 32'd100, 32'd80, 2'b00);
        lit("call_itm", 32'd20, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'd50, 32'd70, 2'b00);
        lit("call_otm", 32'd0, 1'b1, 1'b0);

        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0, 32'd200, 32'd100, 2'b00);
            lit("hold_zero", 32'd0, 1'b0, 1'b0);
        end

        step(1'b0, 1'b1, 32'd90, 32'd120, 2'b01);
        lit("put_itm", 32'd30, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'd200, 32'd150, 2'b01);
        lit("put_otm", 32'd0, 1'b1, 1'b0);

        step(1'b0, 1'b1, 32'd101, 32'd100, 2'b10);
        lit("dig_call", 32'd1000, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd5, 32'd999, 2'b01);
        lit("hold_type_change", 32'd1000, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'd101, 32'd100, 2'b11);
        lit("dig_put_otm", 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'd100, 32'd101, 2'b11);
        lit("dig_put_itm", 32'd1000, 1'b1, 1'b1);

        for (int t = 0; t < 4; t++) begin
            step(1'b0, 1'b1, 32'd77, 32'd77, 2'(t));
            lit("equal", 32'd0, 1'b1, 1'b0);
        end

        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 2'b00);
        lit("call_max", 32'hFFFF_FFFF, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 2'b01);
        lit("put_max", 32'hFFFF_FFFF, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b00);
        lit("call_near_max", 32'd1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        lit("equal_max", 32'd0, 1'b1, 1'b0);

        step(1'b0, 1'b1, 32'd500, 32'd100, 2'b00);
        lit("pre_reset", 32'd400, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'd500, 32'd100, 2'b00);
        lit("rst_over_en", 32'd0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] s;
            logic [31:0] k;
            s = $urandom;
            k = (n % 5 == 0) ? s : $urandom;
            if (n % 7 == 0) s = s >> 24;
            step((n % 17) == 16, $urandom_range(0, 3) != 0, s, k, 2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/payoff_calculator.md
Name: payoff_calculator

Overview:
Registered European option payoff stage at the end of the Monte-Carlo Heston path pipeline. It takes the simulated terminal price S_T and strike K, both unsigned fixed-point values on the same scale. It computes the intrinsic payoff for vanilla and digital calls and puts. The result is held in an output register that updates only when enabled.

Parameters:
WIDTH, 32, bit width of S_T, K and payoff (unsigned).
CASH_AMOUNT, 1, payout for digital (cash-or-nothing) options; WIDTH bits, same scale as S_T/K.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  reset, synchronous, active-high.
en  input  1  enable; when high, payoff register loads the newly computed value.
S_T  input  WIDTH  terminal underlying price, unsigned.
K  input  WIDTH  strike price, unsigned.
option_type  input  2  00 vanilla call, 01 vanilla put, 10 digital call, 11 digital put.
payoff  output  WIDTH  registered payoff, unsigned.
payoff_valid  output  1  registered copy of en; high for the cycle in which payoff holds a freshly computed value.
in_the_money  output  1  registered flag; 1 if the loaded payoff came from an in-the-money comparison.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on a rising clk edge with rst=1, payoff=0, payoff_valid=0 and in_the_money=0. rst has priority over en.
- Latency is 1 cycle. Inputs sampled at rising edge N appear on payoff after edge N. There is no combinational input-to-output path.
- When en=1 and rst=0, the outputs load as follows:
  - 00 call: payoff = S_T-K if S_T>K, else 0.
  - 01 put: payoff = K-S_T if K>S_T, else 0.
  - 10 digital call: payoff = CASH_AMOUNT if S_T>K, else 0.
  - 11 digital put: payoff = CASH_AMOUNT if K>S_T, else 0.
  - in_the_money = the strict comparison used for the selected type.
  - payoff_valid = 1.
- When en=0 and rst=0: payoff and in_the_money hold their previous values regardless of input changes; payoff_valid=0.
- Arithmetic: comparisons are unsigned at full WIDTH. Subtraction is performed only on the winning side, so the result never underflows or wraps. Zero is enforced by the comparison, not by truncation.
- Boundaries:
  - S_T==K yields 0 and in_the_money=0 for all four types.
  - S_T=0 or K=0 and all-ones operands compute correctly with no overflow.
  - Changing option_type while en=0 has no effect.
  - Asserting rst mid-stream clears the outputs on the next edge, even if en=1.
- Inputs are not registered internally; they must be stable around the rising edge.

Decomposition:
- Shared package payoff_pkg holds:
  - the option_type encoding constants: OPT_CALL=2'b00, OPT_PUT=2'b01, OPT_DIG_CALL=2'b10, OPT_DIG_PUT=2'b11;
  - the default WIDTH.
- One natural sub-module: payoff_intrinsic, a purely combinational compare/subtract/select block producing next_payoff and next_itm.
- The top level holds only the enable/reset registers.

Test Plan:
- Reset: rst=1 for one edge with en=0, S_T=123, K=45, type 00 -> after rst drops, payoff=0, payoff_valid=0.
- Vanilla call: en=1, S_T=100, K=80, type 00 -> payoff=20 one edge later, in_the_money=1. Then S_T=50, K=70 -> payoff=0, in_the_money=0.
- Hold: en=0, S_T=200, K=100, type 00 while payoff=0 -> payoff stays 0 and payoff_valid=0 over several edges.
- Vanilla put: en=1, S_T=90, K=120, type 01 -> payoff=30. Then S_T=200, K=150 -> payoff=0.
- Digital and equality cases (CASH_AMOUNT=1000):
  - type 10, S_T=101, K=100 -> payoff=1000.
  - type 11, S_T=101, K=100 -> payoff=0.
  - S_T=K=77 with each type -> payoff=0.
- Extremes and priority:
  - type 00, S_T=32'hFFFFFFFF, K=0 -> payoff=32'hFFFFFFFF.
  - type 01, S_T=0, K=32'hFFFFFFFF -> payoff=32'hFFFFFFFF.
  - rst=1 together with en=1 -> payoff=0.
